// File: rtl/srdl2sv_b2r_arbiter_if.sv
// b2r/r2b register-block link carried between the arbiter (master) and an srdl2sv register block (slave).
interface srdl2sv_b2r_arbiter_if #(
    parameter int BUS_BITS = 32
);
    logic                  b2r_w_vld;
    logic                  b2r_r_vld;
    logic [31:0]           b2r_addr;
    logic [BUS_BITS-1:0]   b2r_data;
    logic [BUS_BITS/8-1:0] b2r_byte_en;
    logic                  r2b_rdy;
    logic                  r2b_err;
    logic [BUS_BITS-1:0]   r2b_data;

    modport master (
        output b2r_w_vld, b2r_r_vld, b2r_addr, b2r_data, b2r_byte_en,
        input  r2b_rdy, r2b_err, r2b_data
    );

    modport slave (
        input  b2r_w_vld, b2r_r_vld, b2r_addr, b2r_data, b2r_byte_en,
        output r2b_rdy, r2b_err, r2b_data
    );
endinterface

// File: rtl/srdl2sv_b2r_arbiter.sv
// Round-robin arbiter sharing one srdl2sv register block between NUM_REQ bus widgets.
// Optional watchdog: define SRDL2SV_ARB_TIMEOUT_EN to complete a stalled transfer with an error.
module srdl2sv_b2r_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int BUS_BITS = 32,
    parameter int TIMEOUT  = 64
) (
    input  logic                            HCLK,
    input  logic                            HRESETn,
    input  logic [NUM_REQ-1:0]              req_w_vld,
    input  logic [NUM_REQ-1:0]              req_r_vld,
    input  logic [NUM_REQ*32-1:0]           req_addr,
    input  logic [NUM_REQ*BUS_BITS-1:0]     req_data,
    input  logic [NUM_REQ*BUS_BITS/8-1:0]   req_byte_en,
    output logic [NUM_REQ-1:0]              req_rdy,
    output logic [NUM_REQ-1:0]              req_err,
    output logic [BUS_BITS-1:0]             req_rdata,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            dbg_state,
    srdl2sv_b2r_arbiter_if.master           reg_if
);

    // Valid/ready: requester i raises req_w_vld[i] or req_r_vld[i] (never both) with stable
    // addr/data/byte_en and holds them until the single cycle in which req_rdy[i] is high;
    // that cycle completes the transfer and req_err[i] is meaningful only then.

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BE_W  = BUS_BITS / 8;

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_e;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2 || TIMEOUT > 65535 || BUS_BITS % 8 != 0)
        begin : g_bad_param
            $error("srdl2sv_b2r_arbiter: parameter out of range");
        end
    endgenerate

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   g_idx_q, g_idx_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;

    logic [NUM_REQ-1:0] req_active;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_active;

`ifdef SRDL2SV_ARB_TIMEOUT_EN
    logic [15:0]        wdog_q;
    logic               wdog_hit;
`endif

    assign req_active   = req_w_vld | req_r_vld;
    assign owner_active = req_active[g_idx_q];
    assign grant        = grant_q;
    assign dbg_state    = (state_q == OWN);
    assign req_rdata    = reg_if.r2b_data;

    // Search upward from last_grant+1, wrapping, so the most recent owner is considered last.
    always_comb begin : p_pick
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        cand       = 0;
        cand_idx   = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!pick_found && req_active[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

`ifdef SRDL2SV_ARB_TIMEOUT_EN
    // Counts OWN cycles that ended without r2b.rdy; cleared whenever the FSM sits in ARB.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wdog_q <= '0;
        end else if (state_q == ARB) begin
            wdog_q <= '0;
        end else if (!reg_if.r2b_rdy) begin
            wdog_q <= wdog_q + 16'd1;
        end
    end

    assign wdog_hit = (wdog_q == 16'(TIMEOUT - 1));
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ARB;
            grant_q      <= '0;
            g_idx_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            g_idx_q      <= g_idx_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        grant_d            = grant_q;
        g_idx_d            = g_idx_q;
        last_grant_d       = last_grant_q;
        req_rdy            = '0;
        req_err            = '0;
        reg_if.b2r_w_vld   = 1'b0;
        reg_if.b2r_r_vld   = 1'b0;
        reg_if.b2r_addr    = '0;
        reg_if.b2r_data    = '0;
        reg_if.b2r_byte_en = '0;

        case (state_q)
            ARB: begin
                if (pick_found) begin
                    state_d           = OWN;
                    g_idx_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                end
            end

            OWN: begin
                reg_if.b2r_w_vld   = req_w_vld[g_idx_q];
                reg_if.b2r_r_vld   = req_r_vld[g_idx_q];
                reg_if.b2r_addr    = req_addr[32*int'(g_idx_q) +: 32];
                reg_if.b2r_data    = req_data[BUS_BITS*int'(g_idx_q) +: BUS_BITS];
                reg_if.b2r_byte_en = req_byte_en[BE_W*int'(g_idx_q) +: BE_W];

                if (!owner_active) begin
                    // Owner abandoned its request: release without completing or rotating.
                    state_d = ARB;
                    grant_d = '0;
                end else if (reg_if.r2b_rdy) begin
                    req_rdy[g_idx_q] = 1'b1;
                    req_err[g_idx_q] = reg_if.r2b_err;
                    last_grant_d     = g_idx_q;
                    state_d          = ARB;
                    grant_d          = '0;
                end
`ifdef SRDL2SV_ARB_TIMEOUT_EN
                else if (wdog_hit) begin
                    reg_if.b2r_w_vld = 1'b0;
                    reg_if.b2r_r_vld = 1'b0;
                    req_rdy[g_idx_q] = 1'b1;
                    req_err[g_idx_q] = 1'b1;
                    last_grant_d     = g_idx_q;
                    state_d          = ARB;
                    grant_d          = '0;
                end
`endif
            end

            default: begin
                state_d = ARB;
                grant_d = '0;
            end
        endcase
    end

    a_grant_onehot0: assert property (@(posedge HCLK) disable iff (!HRESETn) $onehot0(grant_q));
    a_vld_needs_grant: assert property (@(posedge HCLK) disable iff (!HRESETn)
        (reg_if.b2r_w_vld || reg_if.b2r_r_vld) |-> (grant_q != '0));

endmodule
